// File: rtl/sprite_blitter.sv
// Sprite blitter: queues sprite draw commands, reads texels from a synchronous
// ROM and presents one pixel write every two cycles to the SRAM controller.
// Transparent or off-screen pixels are redirected to an invisible row.
module sprite_blitter #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          ROM_AW     = 16,
    parameter logic [15:0] KEY        = 16'hF81F,
    parameter int          PARK_Y     = 511
) (
    input  logic              sram_clk,
    input  logic              reset,
    input  logic              frame_clk,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_base,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [9:0]        program_x,
    output logic [9:0]        program_y,
    output logic [15:0]       program_data,
    output logic              busy,
    output logic              overrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 40 + ROM_AW;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

    state_t            state, next_state;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop, empty;
    logic              frame_d, swap;
    logic              emit, pix_live;
    logic [9:0]        x0, y0, w, h, col, row;
    logic              ph;
    logic [ROM_AW-1:0] ptr;
    logic [9:0]        head_x, head_y, head_w, head_h;
    logic [ROM_AW-1:0] head_base;
    logic              last_col, last_row;
    logic [10:0]       pix_x, pix_y;
    logic              pix_park;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign cmd_ready = (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;
    assign swap      = frame_clk && !frame_d;
    assign rom_addr  = ptr;

    assign {head_x, head_y, head_w, head_h, head_base} = fifo_mem[rd_ptr];

    assign last_col = (col == w - 10'd1);
    assign last_row = (row == h - 10'd1);
    // 11-bit sums so a sprite hanging off the right/bottom edge cannot wrap back on screen
    assign pix_x    = {1'b0, x0} + {1'b0, col};
    assign pix_y    = {1'b0, y0} + {1'b0, row};
    assign pix_park = (rom_data == KEY) || (pix_x >= 11'd640) || (pix_y >= 11'd480);

    // Rising-edge detector on frame_clk, matched to the controller's detector
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) frame_d <= 1'b0;
        else       frame_d <= frame_clk;
    end

    // Command FIFO storage; entries past the count are don't-care
    always_ff @(posedge sram_clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_base};
    end

    // FIFO pointers and occupancy; a frame swap empties it, including a same-cycle push
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (swap) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FSM state register
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next state, FIFO pop and pixel emit strobe
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        emit       = 1'b0;
        unique case (state)
            IDLE: if (!empty) next_state = LOAD;
            LOAD: begin
                pop        = 1'b1;
                next_state = (head_w == '0 || head_h == '0) ? IDLE : DRAW;
            end
            DRAW: if (ph) begin
                emit = 1'b1;
                if (last_col && last_row) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (swap) next_state = IDLE;
    end

    // Sprite geometry latched from the FIFO head
    always_ff @(posedge sram_clk) begin
        if (state == LOAD) begin
            x0 <= head_x;
            y0 <= head_y;
            w  <= head_w;
            h  <= head_h;
        end
    end

    // Raster walk: ROM pointer, column/row counters and the two-cycle phase
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            col <= '0;
            row <= '0;
            ph  <= 1'b0;
        end else if (state == LOAD) begin
            ptr <= head_base;
            col <= '0;
            row <= '0;
            ph  <= 1'b0;
        end else if (state == DRAW) begin
            ph <= ~ph;
            if (ph) begin
                ptr <= ptr + ROM_AW'(1);
                if (last_col) begin
                    col <= '0;
                    row <= row + 10'd1;
                end else begin
                    col <= col + 10'd1;
                end
            end
        end
    end

    // Pixel output register: load on emit, hold one extra cycle, otherwise park
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) begin
            program_x    <= '0;
            program_y    <= 10'(PARK_Y);
            program_data <= '0;
            pix_live     <= 1'b0;
        end else if (swap || (!emit && !pix_live)) begin
            program_x    <= '0;
            program_y    <= 10'(PARK_Y);
            program_data <= '0;
            pix_live     <= 1'b0;
        end else if (emit) begin
            program_x    <= pix_park ? 10'd0 : pix_x[9:0];
            program_y    <= pix_park ? 10'(PARK_Y) : pix_y[9:0];
            program_data <= pix_park ? 16'd0 : rom_data;
            pix_live     <= 1'b1;
        end else begin
            pix_live     <= 1'b0;
        end
    end

    // Overrun flags a frame swap that threw away queued or in-flight work
    always_ff @(posedge sram_clk or posedge reset) begin
        if (reset) overrun <= 1'b0;
        else       overrun <= swap && busy;
    end

endmodule
